dsp_acc4_unpack: RTL and testbench
==================================

Name: dsp_acc4_unpack

Overview:
- Downstream consumer of the 4-input dual-lane DSP accumulator (dsp_acc4_cin).
- Takes the 48-bit packed accumulator result at the final beat of each accumulation group, splits it into low/high lanes, and applies carry-borrow compensation to the high lane.
- Rounds, shifts and saturates each lane to an unsigned pixel.
- Buffers pixel pairs in a small FIFO with a valid/ready output. Because the DSP pipeline cannot stall, upstream throttling is done with a credit-style stall request.

Parameters:
- LANE_W, 24: width of each packed lane; low lane is result[LANE_W-1:0], high lane is result[47:LANE_W].
- FRAC, 8: fractional bits removed by round-and-shift (FRAC >= 1).
- OUT_W, 8: output pixel width, unsigned.
- DEPTH, 4: output FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-high reset
- result_valid  in  1  result beat valid
- result_last  in  1  beat is the final accumulation of a group
- result  in  48  packed signed accumulator result
- out_valid  out  1  pixel pair available
- out_ready  in  1  consumer accepts pair
- out_pix_l  out  OUT_W  low-lane pixel
- out_pix_h  out  OUT_W  high-lane pixel
- stall_req  out  1  upstream must not issue further result_last beats
- overflow  out  1  sticky; a pair was dropped

Behaviour:
- Reset: one clock, reset asynchronous and active-high.
  - All state clears immediately on areset, including mid-operation; in-flight pairs are discarded.
  - Reset values: out_valid=0, out_pix_l=0, out_pix_h=0, stall_req=0, overflow=0, FIFO empty.
- Capture:
  - Only beats with result_valid && result_last enter the pipeline.
  - Any other beat (valid without last, or last without valid) is ignored.
- Stage S1 (edge 1), lane split and compensation:
  - lo = signed result[LANE_W-1:0].
  - hi = signed result[47:LANE_W] + lo[LANE_W-1] (borrow compensation).
  - Width is LANE_W+1 signed.
- Stage S2 (edge 2), rounding:
  - v = (x + 2^(FRAC-1)) >>> FRAC, arithmetic shift.
  - Saturate: v<0 -> 0; v>2^OUT_W-1 -> 2^OUT_W-1.
  - Rounding is round-half-up.
- FIFO write (edge 3):
  - S2 valid pushes the pair {pix_h, pix_l}.
  - out_valid rises the cycle after edge 3, so input-to-out_valid latency is 3 cycles when the FIFO is empty.
  - Throughput is one pair per cycle.
- Output handshake:
  - Head entry is shown on out_pix_l/out_pix_h while out_valid=1.
  - Pop occurs on out_valid && out_ready.
  - Data and out_valid stay stable until popped.
  - When empty, outputs hold their last value and out_valid=0.
- Push while full:
  - Simultaneous push and pop while full is legal; no drop, count unchanged.
  - Push while full without a pop drops the pair and sets overflow=1. overflow stays set until areset.
- Push and pop on an empty FIFO: the push lands; the pop is not possible (out_valid=0).
- stall_req:
  - Combinational from registers: (count + s1_valid + s2_valid) >= DEPTH.
  - A compliant upstream therefore never causes overflow.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Decomposition:
- Package dsp_acc4_pkg holds:
  - constant ACC_W=48;
  - typedef acc_t = logic signed [47:0];
  - typedef pix_pair_t = struct {pix_h, pix_l};
  - function round_sat(x, FRAC, OUT_W).
- One sub-module, sync_fifo_fwft (width, depth, push, pop, full, empty, count), used for the output buffer.
- The split and round pipeline stays in the top module.

Test Plan:
- Basic: result = {24'h000180, 24'h000280}, valid+last, out_ready=1 -> after 3 cycles out_pix_l=3, out_pix_h=2, out_valid for exactly 1 cycle.
- Borrow compensation and clamp: result = 512*2^24 - 256 (high field 0x0001FF, low field 0xFFFF00) -> out_pix_h=2, out_pix_l=0 (low clamps from -1).
- Rounding and saturation: low=0x000180 -> 2 (1.5 rounds up); low=0x00017F -> 1; low=0x010000 -> 255; high=0x000000 -> 0.
- Gating: stream of 4 beats with last only on the 4th, mode-style grouping -> exactly one output pair; beats with last=1, valid=0 -> none.
- Backpressure: out_ready=0, push pairs each cycle honouring stall_req -> stall_req asserts when count+in-flight=4, no overflow. Then out_ready=1 drains 4 pairs in order. Ignoring stall_req with a 5th pair -> overflow=1 and the dropped pair is absent.
- Reset mid-flight: assert areset with 2 pairs in the FIFO and 1 in S1 -> out_valid, stall_req and overflow go to 0 immediately. After release, the next pair emerges with 3-cycle latency.

Source files
------------

// File: rtl/dsp_acc4_pkg.sv
// Shared types and the round/shift/saturate helper for the accumulator unpack path.
package dsp_acc4_pkg;
   localparam int ACC_W = 48;
   localparam int PIX_W = 8;

   typedef logic signed [ACC_W-1:0] acc_t;

   typedef struct packed {
      logic [PIX_W-1:0] pix_h;
      logic [PIX_W-1:0] pix_l;
   } pix_pair_t;

   // Round-half-up, drop frac bits, clamp to [0, 2^out_w-1]; x is pre-sign-extended.
   function automatic logic [31:0] round_sat(input logic signed [ACC_W:0] x,
                                             input int frac, input int out_w);
      logic signed [ACC_W:0] half;
      logic signed [ACC_W:0] t;
      logic [31:0]           r;
      half = (ACC_W+1)'(1) << (frac - 1);
      t    = (x + half) >>> frac;
      if (t[ACC_W])
         r = '0;
      else if ((t >> out_w) != '0)
         r = 32'hFFFF_FFFF >> (32 - out_w);
      else
         r = t[31:0];
      return r;
   endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; the head stays on dout, and the last popped word is held when empty.
module sync_fifo_fwft #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] hold;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO only lands when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? hold : mem[rd_ptr];

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hold   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold   <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/dsp_acc4_unpack.sv
// Splits the packed dual-lane accumulator result, compensates the high-lane borrow,
// rounds/saturates both lanes to pixels and buffers the pairs behind a valid/ready port.
module dsp_acc4_unpack
   import dsp_acc4_pkg::*;
#(
   parameter int LANE_W = 24,
   parameter int FRAC   = 8,
   parameter int OUT_W  = 8,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             result_valid,
   input  logic             result_last,
   input  acc_t             result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_pix_l,
   output logic [OUT_W-1:0] out_pix_h,
   output logic             stall_req,
   output logic             overflow
);
   localparam int STAGES = 2;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic [STAGES:1]         vld_pipe;
   logic                    cap, pop;
   logic signed [LANE_W:0]  lo_n, hi_n, s1_lo, s1_hi;
   logic [OUT_W-1:0]        s2_pix_l, s2_pix_h;
   logic [2*OUT_W-1:0]      fifo_dout;
   logic                    fifo_full, fifo_empty;
   logic [CW-1:0]           fifo_count;
   logic [CW:0]             occ;

   assign cap  = result_valid && result_last;
   assign lo_n = {result[LANE_W-1], result[LANE_W-1:0]};
   // A negative low lane borrowed one from the high field when the lanes were packed.
   assign hi_n = {result[ACC_W-1], result[ACC_W-1:LANE_W]} + {{LANE_W{1'b0}}, result[LANE_W-1]};

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         vld_pipe <= '0;
         s1_lo    <= '0;
         s1_hi    <= '0;
         s2_pix_l <= '0;
         s2_pix_h <= '0;
         overflow <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], cap};
         if (cap) begin
            s1_lo <= lo_n;
            s1_hi <= hi_n;
         end
         if (vld_pipe[1]) begin
            s2_pix_l <= OUT_W'(round_sat({{(ACC_W-LANE_W){s1_lo[LANE_W]}}, s1_lo}, FRAC, OUT_W));
            s2_pix_h <= OUT_W'(round_sat({{(ACC_W-LANE_W){s1_hi[LANE_W]}}, s1_hi}, FRAC, OUT_W));
         end
         if (vld_pipe[STAGES] && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   sync_fifo_fwft #(.WIDTH(2*OUT_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .areset (areset),
      .push   (vld_pipe[STAGES]),
      .din    ({s2_pix_h, s2_pix_l}),
      .pop    (pop),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign out_valid              = !fifo_empty;
   assign pop                    = out_valid && out_ready;
   assign {out_pix_h, out_pix_l} = fifo_dout;

   // In-flight beats cannot be held back, so they are reserved against FIFO space.
   assign occ       = (CW+1)'(fifo_count) + (CW+1)'(vld_pipe[1]) + (CW+1)'(vld_pipe[2]);
   assign stall_req = (occ >= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_dsp_acc4_unpack.sv
// Directed-vector bench for dsp_acc4_unpack with a queue scoreboard and a decoupled output monitor.
module tb_dsp_acc4_unpack;
   import dsp_acc4_pkg::*;

   logic        clk = 1'b0;
   logic        areset = 1'b0;
   logic        result_valid = 1'b0;
   logic        result_last = 1'b0;
   logic [47:0] result = '0;
   logic        out_ready = 1'b0;
   logic        out_valid, stall_req, overflow;
   logic [7:0]  out_pix_l, out_pix_h;

   int          checks = 0;
   int          errors = 0;
   pix_pair_t   exp_q[$];
   pix_pair_t   mon_e;

   logic [47:0] vec_r [6] = '{ {24'h0001FF, 24'hFFFF00}, {24'h000000, 24'h000180},
                               {24'h010000, 24'h00017F}, {24'h000000, 24'h010000},
                               {24'h7FFFFF, 24'hFFFFFF}, {24'hFFFFFF, 24'h000080} };
   logic [7:0]  vec_l [6] = '{8'd0, 8'd2, 8'd1, 8'd255, 8'd0,   8'd1};
   logic [7:0]  vec_h [6] = '{8'd2, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};

   dsp_acc4_unpack dut (
      .clk          (clk),
      .areset       (areset),
      .result_valid (result_valid),
      .result_last  (result_last),
      .result       (result),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pix_l    (out_pix_l),
      .out_pix_h    (out_pix_h),
      .stall_req    (stall_req),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, wanted %0d", name, act, req);
      end
   endtask

   task automatic expect_pair(input logic [7:0] l, input logic [7:0] h);
      pix_pair_t p;
      p.pix_l = l;
      p.pix_h = h;
      exp_q.push_back(p);
   endtask

   // Called at posedge+1; presents one beat for exactly one clock.
   task automatic drive(input logic [47:0] r, input logic v, input logic l);
      result       = r;
      result_valid = v;
      result_last  = l;
      @(posedge clk); #1;
      result_valid = 1'b0;
      result_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!areset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pair: got l=%0d h=%0d, wanted no output", out_pix_l, out_pix_h);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_pix_l", out_pix_l, mon_e.pix_l);
            check("sb_pix_h", out_pix_h, mon_e.pix_h);
         end
      end
   end

   initial begin
      int n;
      int cyc;
      #1 areset = 1'b1;
      idle(2);
      check("rst_out_valid", out_valid, 0);
      check("rst_pix_l", out_pix_l, 0);
      check("rst_pix_h", out_pix_h, 0);
      check("rst_stall_req", stall_req, 0);
      check("rst_overflow", overflow, 0);
      areset    = 1'b0;
      out_ready = 1'b1;
      idle(1);

      // basic latency and single-cycle valid
      expect_pair(8'd3, 8'd2);
      drive({24'h000180, 24'h000280}, 1'b1, 1'b1);
      idle(1);
      check("lat_edge2_valid", out_valid, 0);
      idle(1);
      check("lat_edge3_valid", out_valid, 1);
      check("lat_edge3_pix_l", out_pix_l, 3);
      idle(1);
      check("one_cycle_valid", out_valid, 0);
      check("hold_pix_l", out_pix_l, 3);

      // borrow, rounding and saturation vectors back to back
      for (int i = 0; i < 6; i++) begin
         expect_pair(vec_l[i], vec_h[i]);
         drive(vec_r[i], 1'b1, 1'b1);
      end
      wait_drain(20);

      // gating: only valid && last enters
      drive({24'h000111, 24'h000222}, 1'b1, 1'b0);
      drive({24'h000333, 24'h000444}, 1'b1, 1'b0);
      drive({24'h000555, 24'h000666}, 1'b1, 1'b0);
      expect_pair(8'd4, 8'd3);
      drive({24'h000300, 24'h000400}, 1'b1, 1'b1);
      drive({24'h000900, 24'h000900}, 1'b0, 1'b1);
      drive({24'h000A00, 24'h000A00}, 1'b0, 1'b1);
      wait_drain(20);
      idle(5);

      // backpressure with a compliant upstream
      out_ready = 1'b0;
      n   = 0;
      cyc = 0;
      while (n < 4 && cyc < 20) begin
         if (!stall_req) begin
            expect_pair(8'(n + 5), 8'(n + 1));
            drive({24'((n + 1) * 256), 24'((n + 5) * 256)}, 1'b1, 1'b1);
            n++;
         end else begin
            idle(1);
         end
         cyc++;
      end
      check("bp_issued", n, 4);
      check("bp_stall_at_4", stall_req, 1);
      idle(3);
      check("bp_stall_full", stall_req, 1);
      check("bp_no_overflow", overflow, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_head_pix_l", out_pix_l, 5);

      // ignore stall_req: fifth pair is dropped
      drive({24'h000900, 24'h000900}, 1'b1, 1'b1);
      idle(3);
      check("ovf_set", overflow, 1);
      out_ready = 1'b1;
      wait_drain(20);
      idle(4);
      check("ovf_drained_valid", out_valid, 0);
      check("ovf_sticky", overflow, 1);
      check("ovf_stall_clear", stall_req, 0);

      // reset mid-flight: 2 pairs buffered, 1 in S1
      out_ready = 1'b0;
      drive({24'h000700, 24'h000700}, 1'b1, 1'b1);
      drive({24'h000800, 24'h000800}, 1'b1, 1'b1);
      idle(2);
      drive({24'h000A00, 24'h000A00}, 1'b1, 1'b1);
      check("pre_rst_valid", out_valid, 1);
      areset = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_stall_req", stall_req, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_pix_l", out_pix_l, 0);
      @(posedge clk); #1;
      areset    = 1'b0;
      out_ready = 1'b1;
      expect_pair(8'd6, 8'd5);
      drive({24'h000500, 24'h000600}, 1'b1, 1'b1);
      idle(1);
      check("post_rst_edge2_valid", out_valid, 0);
      idle(1);
      check("post_rst_edge3_valid", out_valid, 1);
      wait_drain(10);
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
